apb_mem_completer: RTL and testbench
====================================

# apb_mem_completer

Parametrised APB completer (slave) RTL that backs a word-addressed memory window. It supports configurable data width, depth, base address and wait states, plus byte strobes and a 2-bit error response. It is the next-generation APB endpoint for the AHB-to-APB side of the interconnect and is driven by the existing APB master agent. The legacy interface carries no select or strobes, so `psel` and `pstrb` are added here.

## Interface
- ADDR_WIDTH, 32, width of `paddr`.
- DATA_WIDTH, 32, width of `pwdata`/`prdata`; legal values are 8, 16, 32, 64.
- DEPTH, 256, number of DATA_WIDTH-bit words in the window; must be ≥ 2.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.
- WAIT_CYCLES, 0, extra access-phase cycles before `pready`; legal range 0–15.

Ports:
- pclk  input  1  clock; all logic on the rising edge.
- prst  input  1  reset, synchronous, active-low.
- psel  input  1  completer selected.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes; ignored on reads.
- pready  output  1  transfer completes this cycle.
- prdata  output  DATA_WIDTH  read data; valid only while `pready`=1 and the transfer is a read.
- presp  output  2  response: 00 OKAY, 10 SLVERR (out of range), 11 misaligned; 01 is never driven.

## Operation
- **Address decode.**
  - off = paddr − BASE_ADDR.
  - idx = off >> log2(DATA_WIDTH/8).
  - Out of range: paddr < BASE_ADDR, or idx ≥ DEPTH.
  - Misaligned: paddr[log2(DATA_WIDTH/8)−1:0] ≠ 0. Misaligned takes priority over out-of-range.
  - For DATA_WIDTH = 8, misaligned never fires.
- **FSM states.** IDLE, ACCESS.
  - IDLE: when psel=1 and penable=0 (setup), capture paddr, pwrite, pwdata, pstrb and the decode result. Load cnt = WAIT_CYCLES, then go to ACCESS.
  - ACCESS with cnt ≠ 0: decrement cnt; `pready` stays 0.
  - ACCESS with cnt = 0: the registered `pready` is 1 for exactly this cycle. At the end of the cycle, commit the write if any, then return to IDLE.
  - ACCESS with psel=0 or penable=0 before completion (protocol abort): go to IDLE; no write, and `pready`, `presp` and `prdata` return to their reset values.
- **Writes.** For each byte b with pstrb[b]=1, mem[idx] byte b ← captured pwdata byte b. Bytes with pstrb=0 are unchanged. Erroring writes never modify memory.
- **Reads.** `prdata` = mem[idx] during the `pready` cycle; 0 on an error response and whenever `pready`=0.
- **Response.** `presp` carries the captured response during the `pready` cycle and is 00 otherwise.
- **Memory contents.** Not reset. Reset clears control state only.

## Timing
- **Reset values.** While prst=0 at a rising edge: state = IDLE, cnt = 0, `pready` = 0, `prdata` = 0, `presp` = 00. This holds even mid-transfer; a pending write is dropped.
- **Latency.** With setup in cycle T0, `pready` = 1 in cycle T1 + WAIT_CYCLES. With WAIT_CYCLES = 0 this is a zero-wait APB transfer: 2 cycles per transfer.
- **Write visibility.** A write is visible to a read whose setup starts in the cycle after the write's `pready` cycle.
- **Back-to-back.** A new setup in the cycle immediately after the `pready` cycle is accepted from IDLE with no idle gap. Sustained throughput is one transfer per (2 + WAIT_CYCLES) cycles.
- **Input sampling.** Access-phase inputs are not re-sampled; the values captured at setup are used.
- **psel=1 with penable=1 while in IDLE** (no setup seen): ignored, `pready` stays 0.
- **Wrap-around.** Address arithmetic is ADDR_WIDTH bits, unsigned. Address underflow (paddr < BASE_ADDR) is detected by comparison, not by wrapped subtraction.

## Test plan
- **Reset.** Hold prst=0 for 3 cycles mid-ACCESS with WAIT_CYCLES=3 → `pready`=0, `presp`=00, `prdata`=0; a subsequent read of the target word shows no write occurred.
- **Zero-wait write and read.** Write 0xDEADBEEF to BASE_ADDR+0x10 with pstrb=4'hF, then read the same address → `pready` in T1 each time, `prdata`=0xDEADBEEF, `presp`=00, 4 cycles total.
- **Byte strobes.** Write 0xFFFFFFFF, then write 0x11223344 with pstrb=4'b0101, then read → 0xFF22FF44.
- **Wait states.** WAIT_CYCLES=3: `pready` first high 4 cycles after setup and high for exactly 1 cycle. Five back-to-back reads take 25 cycles.
- **Errors.** Read of address BASE_ADDR+4·DEPTH → `presp`=10, `prdata`=0. Write to address 0x...02 → `presp`=11, and the target word is unchanged on readback.
- **Abort.** With WAIT_CYCLES=2, drop penable in the second access cycle → no `pready`, memory unchanged, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_mem_completer.sv
// APB completer backing a word-addressed memory window with byte strobes,
// programmable wait states and OKAY / SLVERR / misaligned responses.
module apb_mem_completer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic [1:0]              presp
);

  localparam int   LANES     = DATA_WIDTH / 8;
  localparam int   SHIFT     = $clog2(LANES);
  localparam int   IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic                    pready_reg;
  logic [1:0]              presp_reg;
  logic                    write_reg;
  logic [IDXW-1:0]         idx_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [LANES-1:0]        strb_reg;
  logic [1:0]              resp_reg;

  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   word;
  logic                    misaligned;
  logic                    out_of_range;
  logic [1:0]              resp_live;
  logic [IDXW-1:0]         idx_live;
  logic                    setup;
  logic                    rd_fire;
  logic                    rd_ok;
  logic [IDXW-1:0]         rd_idx;
  logic                    wr_en;

  // Underflow is caught by the compare, so the wrapped offset is never trusted alone.
  assign off          = paddr - BASE_ADDR;
  assign word         = off >> SHIFT;
  assign misaligned   = (paddr & ADDR_WIDTH'(LANES - 1)) != '0;
  assign out_of_range = (paddr < BASE_ADDR) || (word >= ADDR_WIDTH'(DEPTH));
  assign resp_live    = misaligned ? 2'b11 : (out_of_range ? 2'b10 : 2'b00);
  assign idx_live     = word[IDXW-1:0];

  assign setup = psel && !penable;

  // The read is launched on the edge that raises pready, so read data and pready line up.
  assign rd_fire = (state_reg == IDLE && setup && ZERO_WAIT) ||
                   (state_reg == ACCESS && !pready_reg && cnt_reg == 4'd1 && psel && penable);
  assign rd_ok   = (state_reg == IDLE) ? (!pwrite && resp_live == 2'b00)
                                       : (!write_reg && resp_reg == 2'b00);
  assign rd_idx  = (state_reg == IDLE) ? idx_live : idx_reg;
  assign wr_en   = prst && pready_reg && write_reg && (resp_reg == 2'b00);

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      pready_reg <= 1'b0;
      presp_reg  <= 2'b00;
    end else begin
      pready_reg <= 1'b0;
      presp_reg  <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (setup) begin
            write_reg <= pwrite;
            idx_reg   <= idx_live;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            resp_reg  <= resp_live;
            cnt_reg   <= 4'(WAIT_CYCLES);
            state_reg <= ACCESS;
            if (ZERO_WAIT) begin
              pready_reg <= 1'b1;
              presp_reg  <= resp_live;
            end
          end
        end
        ACCESS: begin
          if (pready_reg) begin
            state_reg <= IDLE;
          end else if (!(psel && penable)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              pready_reg <= 1'b1;
              presp_reg  <= resp_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One byte-wide memory per lane gives per-byte write enables.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_reg;

    always_ff @(posedge pclk) begin
      if (wr_en && strb_reg[gi]) begin
        mem[idx_reg] <= wdata_reg[gi*8 +: 8];
      end
    end

    always_ff @(posedge pclk) begin
      if (!prst) begin
        rd_reg <= '0;
      end else if (rd_fire && rd_ok) begin
        rd_reg <= mem[rd_idx];
      end else begin
        rd_reg <= '0;
      end
    end

    assign prdata[gi*8 +: 8] = rd_reg;
  end

  assign pready = pready_reg;
  assign presp  = presp_reg;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: a zero-wait and a three-wait instance share one
// bus (separate psel), checked against a word-array reference model.
module tb_apb_mem_completer;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          W1    = 3;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready_w [2];
  logic [31:0] prdata_w [2];
  logic [1:0]  presp_w  [2];

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [2][DEPTH];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_mem_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                      .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_w[0]), .prdata(prdata_w[0]), .presp(presp_w[0]));

  apb_mem_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                      .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) u_dut1 (
    .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_w[1]), .prdata(prdata_w[1]), .presp(presp_w[1]));

  function automatic int waitc(input int w);
    return (w == 0) ? 0 : W1;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp_rd = rd; v.exp_resp = resp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word array, byte merge, error classes by plain arithmetic.
  task automatic model(input int w, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] erd, output logic [1:0] eresp);
    int unsigned idx;
    erd = '0;
    if (addr % 4 != 0) begin
      eresp = 2'b11;
    end else if (addr < BASE || (addr - BASE) / 4 >= DEPTH) begin
      eresp = 2'b10;
    end else begin
      eresp = 2'b00;
      idx = (addr - BASE) / 4;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[w][idx][8*b +: 8] = data[8*b +: 8];
      end else begin
        erd = ref_mem[w][idx];
      end
    end
  endtask

  task automatic xfer(input int w, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rd, output logic [1:0] resp,
                      output int lat);
    if (w == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 1;
    while (!pready_w[w] && lat < 40) begin
      check("wait_outputs", {prdata_w[w], presp_w[w]}, 34'h0);
      @(posedge pclk); #1;
      lat++;
    end
    rd = prdata_w[w];
    resp = presp_w[w];
    @(posedge pclk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    check("pready_single", pready_w[w], 1'b0);
  endtask

  task automatic apply(input int w, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] exp_rd, input logic [1:0] exp_resp);
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
    xfer(w, wr, addr, data, strb, rd, resp, lat);
    $display("xfer dut%0d %s addr=%08h wdata=%08h strb=%h rdata=%08h resp=%0d lat=%0d",
             w, wr ? "WR" : "RD", addr, data, strb, rd, resp, lat);
    check("latency", lat, 1 + waitc(w));
    check("presp", resp, exp_resp);
    if (!wr) check("prdata", rd, exp_rd);
  endtask

  task automatic model_apply(input int w, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] erd;
    logic [1:0]  eresp;
    model(w, wr, addr, data, strb, erd, eresp);
    apply(w, wr, addr, data, strb, erd, eresp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] erd, old;
    logic [1:0]  eresp;
    logic [31:0] addr;
    int unsigned t0;
    int          r;

    tbl.push_back(mk(1, BASE + 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00));
    tbl.push_back(mk(0, BASE + 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(1, BASE + 32'h20,  32'hFFFFFFFF, 4'hF, 32'h0,        2'b00));
    tbl.push_back(mk(1, BASE + 32'h20,  32'h11223344, 4'h5, 32'h0,        2'b00));
    tbl.push_back(mk(0, BASE + 32'h20,  32'h0,        4'h0, 32'hFF22FF44, 2'b00));
    tbl.push_back(mk(0, BASE + 32'h400, 32'h0,        4'h0, 32'h0,        2'b10));
    tbl.push_back(mk(1, BASE + 32'h12,  32'h0,        4'hF, 32'h0,        2'b11));
    tbl.push_back(mk(0, BASE + 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(0, BASE - 32'h4,   32'h0,        4'h0, 32'h0,        2'b10));
    tbl.push_back(mk(1, BASE + 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00));
    tbl.push_back(mk(0, BASE + 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00));
    tbl.push_back(mk(0, 32'hFFFFFFFC,   32'h0,        4'h0, 32'h0,        2'b10));
    tbl.push_back(mk(1, BASE + 32'h400, 32'h12345678, 4'hF, 32'h0,        2'b10));
    tbl.push_back(mk(0, BASE + 32'h1,   32'h0,        4'h0, 32'h0,        2'b11));
    tbl.push_back(mk(0, BASE + 32'h403, 32'h0,        4'h0, 32'h0,        2'b11));
    tbl.push_back(mk(1, BASE + 32'h20,  32'hAABBCCDD, 4'h0, 32'h0,        2'b00));
    tbl.push_back(mk(0, BASE + 32'h20,  32'h0,        4'h0, 32'hFF22FF44, 2'b00));

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    for (int w = 0; w < 2; w++) begin
      check("reset_pready", pready_w[w], 1'b0);
      check("reset_presp", presp_w[w], 2'b00);
      check("reset_prdata", prdata_w[w], 32'h0);
    end
    prst = 1'b1;
    @(posedge pclk); #1;

    // Fill both memories so every later read has a defined expectation
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++)
        model_apply(w, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

    // Directed table on both instances
    for (int w = 0; w < 2; w++) begin
      t0 = cyc;
      foreach (tbl[i]) begin
        model(w, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, erd, eresp);
        apply(w, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_rd, tbl[i].exp_resp);
        if (w == 0 && i == 1) check("zero_wait_wr_rd_cycles", cyc - t0, 4);
      end
    end

    // Reset held 3 cycles in the middle of a wait-state write
    old = ref_mem[1][16];
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h40;
    pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      check("midreset_pready", pready_w[1], 1'b0);
      check("midreset_presp", presp_w[1], 2'b00);
      check("midreset_prdata", prdata_w[1], 32'h0);
    end
    prst = 1'b1;
    // psel+penable with no preceding setup must be ignored
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      check("no_setup_pready", pready_w[1], 1'b0);
    end
    psel1 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    apply(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, old, 2'b00);

    // Abort: bus drops in the second access cycle
    old = ref_mem[1][17];
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h44;
    pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel1 = 1'b0; penable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("abort_pready", pready_w[1], 1'b0);
      @(posedge pclk); #1;
    end
    apply(1, 1'b0, BASE + 32'h44, 32'h0, 4'h0, old, 2'b00);
    model_apply(1, 1'b1, BASE + 32'h44, 32'h0BADF00D, 4'hF);
    model_apply(1, 1'b0, BASE + 32'h44, 32'h0, 4'h0);

    // Five back-to-back wait-state reads
    t0 = cyc;
    for (int k = 0; k < 5; k++) model_apply(1, 1'b0, BASE + 32'(4 * k), 32'h0, 4'h0);
    check("b2b_five_reads_cycles", cyc - t0, 25);

    // Randomised traffic against the reference model
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 120; n++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        else if (r == 8) addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
        else             addr = 32'($urandom_range(0, BASE - 1));
        model_apply(w, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
